// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder front end.
// Latency: none (constants and pure functions only).
// Backpressure: none.
// Contents: quadrature state codes, qdelta step classifier, direction
// constants and the arming state type used by rotary_decoder.
package rotary_pkg;

  // Quadrature states, bit 1 = A, bit 0 = B.
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  // qdelta result codes: the two's-complement reading of INC/DEC is +1/-1.
  localparam logic [1:0] QD_NONE = 2'b00;
  localparam logic [1:0] QD_INC  = 2'b01;
  localparam logic [1:0] QD_ILL  = 2'b10;
  localparam logic [1:0] QD_DEC  = 2'b11;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic {ST_WAIT, ST_ARMED} arm_state_t;

  // Successor of a state along the CW sequence 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

  // Classify one sampled transition; both bits changing is the only
  // non-adjacent move and is reported as illegal.
  function automatic logic [1:0] qdelta(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur)               return QD_NONE;
    else if (cur == cw_next(prev)) return QD_INC;
    else if (prev == cw_next(cur)) return QD_DEC;
    else                           return QD_ILL;
  endfunction

endpackage

// File: rtl/rotary_decoder_if.sv
// Pin/event bundle between the board encoder and rotary_decoder.
// Latency: none (wiring only).
// Backpressure: none; every output is a level or a one-cycle pulse.
// master = pin/user side, slave = decoder. 'release' is a reserved word,
// so the release pulse is carried as release_o.
interface rotary_decoder_if #(
  parameter int WIDTH = 8
);
  logic             rotA;
  logic             rotB;
  logic             rotCTR;
  logic             clear;
  logic             rotAreg;
  logic             rotBreg;
  logic             rotCTRreg;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] position;
  logic             press;
  logic             release_o;
  logic             error;

  modport master (
    output rotA, rotB, rotCTR, clear,
    input  rotAreg, rotBreg, rotCTRreg, step, dir, position, press, release_o, error
  );

  modport slave (
    input  rotA, rotB, rotCTR, clear,
    output rotAreg, rotBreg, rotCTRreg, step, dir, position, press, release_o, error
  );
endinterface

// File: rtl/rotary_debounce.sv
// Run-length debouncer for one raw pin.
// Latency: a level stable from edge k appears on 'level' at edge k+DEPTH-1.
// Backpressure: none.
// Ports: clk, reset (sync, active high), din (raw pin), level (debounced),
// valid (sticky, set the first time the history holds a full run).
module rotary_debounce #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic valid
);

  logic [DEPTH-1:0] hist_q, hist_d;
  logic             level_q, level_d;
  logic             valid_q, valid_d;

  // Decisions are taken on the history including this cycle's sample so the
  // level moves on the same edge that completes the run.
  always_comb begin
    hist_d  = {hist_q[DEPTH-2:0], din};
    level_d = level_q;
    if (&hist_d)       level_d = 1'b1;
    else if (~|hist_d) level_d = 1'b0;
    valid_d = valid_q | (&hist_d) | (~|hist_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  assign level = level_q;
  assign valid = valid_q;

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: debounce A/B/CTR, decode quadrature, count steps.
// Latency: events and position/dir update one edge after the debounced change.
// Backpressure: none; pulses last one cycle and must be sampled every cycle.
// Ports: clk, reset (sync, active high, dominates clear), bus (slave modport:
// raw pins + clear in; debounced levels, step/dir/position, press/release/error out).
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SPD       = 4,
  parameter int WRAP      = 1,
  parameter int INVERT_AB = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  rotary_decoder_if.slave       bus
);

  localparam logic               INV     = (INVERT_AB != 0);
  localparam logic signed [3:0]  SPD_POS = 4'(SPD);
  localparam logic signed [3:0]  SPD_NEG = -SPD_POS;
  localparam logic [WIDTH-1:0]   POS_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0]   POS_MAX = '1;

  logic a_lvl, a_vld, b_lvl, b_vld, c_lvl, c_vld;

  rotary_debounce #(.DEPTH(DEPTH)) u_deb_a (.clk(clk), .reset(reset), .din(bus.rotA),   .level(a_lvl), .valid(a_vld));
  rotary_debounce #(.DEPTH(DEPTH)) u_deb_b (.clk(clk), .reset(reset), .din(bus.rotB),   .level(b_lvl), .valid(b_vld));
  rotary_debounce #(.DEPTH(DEPTH)) u_deb_c (.clk(clk), .reset(reset), .din(bus.rotCTR), .level(c_lvl), .valid(c_vld));

  // Outputs are forced low until their channel has seen a full run, so an
  // inverted channel still reads 0 out of reset.
  assign bus.rotAreg   = a_vld & (a_lvl ^ INV);
  assign bus.rotBreg   = b_vld & (b_lvl ^ INV);
  assign bus.rotCTRreg = c_vld & c_lvl;

  logic [1:0] cur_ab;
  assign cur_ab = {bus.rotAreg, bus.rotBreg};

  arm_state_t        state_q, state_d;
  logic [1:0]        prev_ab_q, prev_ab_d;
  logic              prev_ctr_q, prev_ctr_d;
  logic signed [3:0] acc_q, acc_d, sum;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d, press_q, press_d, rel_q, rel_d, err_q, err_d;
  logic [1:0]        qd;

  always_comb begin
    state_d    = state_q;
    prev_ab_d  = prev_ab_q;
    prev_ctr_d = prev_ctr_q;
    acc_d      = acc_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    err_d      = 1'b0;
    sum        = acc_q;
    qd         = qdelta(prev_ab_q, cur_ab);

    case (state_q)
      // Arming cycle only captures the current levels, so nothing counts
      // or pulses on the way out of reset.
      ST_WAIT: begin
        if (a_vld && b_vld && c_vld) begin
          state_d    = ST_ARMED;
          prev_ab_d  = cur_ab;
          prev_ctr_d = bus.rotCTRreg;
        end
      end
      ST_ARMED: begin
        prev_ab_d  = cur_ab;
        prev_ctr_d = bus.rotCTRreg;
        press_d    = ~prev_ctr_q & bus.rotCTRreg;
        rel_d      = prev_ctr_q & ~bus.rotCTRreg;
        case (qd)
          QD_INC:  sum = acc_q + 4'sd1;
          QD_DEC:  sum = acc_q - 4'sd1;
          QD_NONE: sum = acc_q;
          default: sum = acc_q;
        endcase
        if (qd == QD_ILL) begin
          err_d = 1'b1;
          acc_d = '0;
        end else if (sum == SPD_POS) begin
          step_d = 1'b1;
          dir_d  = DIR_CW;
          acc_d  = '0;
          if (WRAP != 0 || pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
        end else if (sum == SPD_NEG) begin
          step_d = 1'b1;
          dir_d  = DIR_CCW;
          acc_d  = '0;
          if (WRAP != 0 || pos_q != '0) pos_d = pos_q - POS_ONE;
        end else begin
          acc_d = sum;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Clear overrides the count but leaves step/dir reporting intact.
    if (bus.clear) begin
      pos_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      prev_ab_q  <= S00;
      prev_ctr_q <= 1'b0;
      acc_q      <= '0;
      pos_q      <= '0;
      dir_q      <= DIR_CCW;
      step_q     <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ab_q  <= prev_ab_d;
      prev_ctr_q <= prev_ctr_d;
      acc_q      <= acc_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.position  = pos_q;
  assign bus.press     = press_q;
  assign bus.release_o = rel_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder: a wrapping and a saturating instance
// share the same pin stimulus (INVERT_AB=1, DEPTH=4, SPD=4, WIDTH=8).
module tb_rotary_decoder;
  import rotary_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic pin_a, pin_b, pin_c, clr;

  always #5 clk = ~clk;

  rotary_decoder_if #(.WIDTH(8)) ifw ();
  rotary_decoder_if #(.WIDTH(8)) ifs ();

  assign ifw.rotA = pin_a;  assign ifs.rotA = pin_a;
  assign ifw.rotB = pin_b;  assign ifs.rotB = pin_b;
  assign ifw.rotCTR = pin_c; assign ifs.rotCTR = pin_c;
  assign ifw.clear = clr;   assign ifs.clear = clr;

  rotary_decoder #(.WIDTH(8), .DEPTH(4), .SPD(4), .WRAP(1), .INVERT_AB(1))
    dut_w (.clk(clk), .reset(reset), .bus(ifw));
  rotary_decoder #(.WIDTH(8), .DEPTH(4), .SPD(4), .WRAP(0), .INVERT_AB(1))
    dut_s (.clk(clk), .reset(reset), .bus(ifs));

  typedef struct {
    logic [1:0] ab;      // target debounced {A,B}
    int         steps;   // step pulses expected in the window
    int         dir;
    int         pos_w;   // wrapping instance position after the window
    int         pos_s;   // saturating instance position after the window
    int         errs;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void add(logic [1:0] ab, int steps, int dir, int pw, int ps, int errs);
    vec_t v;
    v.ab = ab; v.steps = steps; v.dir = dir; v.pos_w = pw; v.pos_s = ps; v.errs = errs;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pins are inverted relative to the debounced A/B.
  task automatic drive_ab(input logic [1:0] ab);
    pin_a = ~ab[1];
    pin_b = ~ab[0];
  endtask

  task automatic run_win(input int n, output int sw, output int ss, output int ew,
                         output int pr, output int rl);
    sw = 0; ss = 0; ew = 0; pr = 0; rl = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      sw += int'(ifw.step);
      ss += int'(ifs.step);
      ew += int'(ifw.error);
      pr += int'(ifw.press);
      rl += int'(ifw.release_o);
    end
  endtask

  initial begin
    int sw, ss, ew, pr, rl, pw0, dr;

    // two CCW detents from 00; dir still at its reset value
    add(S01,0,0,0,0,0);   add(S11,0,0,0,0,0);   add(S10,0,0,0,0,0);   add(S00,1,0,255,0,0);
    add(S01,0,0,255,0,0); add(S11,0,0,255,0,0); add(S10,0,0,255,0,0); add(S00,1,0,254,0,0);
    // two CCW edges then two CW edges: no step, acc back to 0
    add(S01,0,0,254,0,0); add(S11,0,0,254,0,0); add(S01,0,0,254,0,0); add(S00,0,0,254,0,0);
    // eight CW detents: wrap 254 -> 6, saturating 0 -> 8
    for (int d = 0; d < 8; d++) begin
      pw0 = (254 + d) % 256;
      dr  = (d == 0) ? 0 : 1;
      add(S10,0,dr,pw0,d,0); add(S11,0,dr,pw0,d,0); add(S01,0,dr,pw0,d,0);
      add(S00,1,1,(255 + d) % 256,d + 1,0);
    end
    // one CW edge, then an illegal jump 10 -> 01 zeroes acc; four more CW edges step
    add(S10,0,1,6,8,0); add(S01,0,1,6,8,1); add(S00,0,1,6,8,0);
    add(S10,0,1,6,8,0); add(S11,0,1,6,8,0); add(S01,1,1,7,9,0);
    // two CCW detents from 01
    add(S11,0,1,7,9,0); add(S10,0,1,7,9,0); add(S00,0,1,7,9,0); add(S01,1,0,6,8,0);
    add(S11,0,0,6,8,0); add(S10,0,0,6,8,0); add(S00,0,0,6,8,0); add(S01,1,0,5,7,0);

    // ---- reset and arming ----
    pin_a = 1'b1; pin_b = 1'b1; pin_c = 1'b1; clr = 1'b0; reset = 1'b1;
    tick(); tick();
    chk("rst position", ifw.position, 0);
    chk("rst rotAreg", ifw.rotAreg, 0);
    chk("rst rotCTRreg", ifw.rotCTRreg, 0);
    chk("rst dir", ifw.dir, 0);
    chk("rst step", ifw.step, 0);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("arm%0d rotAreg", e), ifw.rotAreg, 0);
      chk($sformatf("arm%0d rotBreg", e), ifw.rotBreg, 0);
      chk($sformatf("arm%0d rotCTRreg", e), ifw.rotCTRreg, (e == 4) ? 1 : 0);
    end
    run_win(6, sw, ss, ew, pr, rl);
    chk("arm steps", sw, 0);
    chk("arm press", pr, 0);
    chk("arm error", ew, 0);
    chk("arm position", ifw.position, 0);

    // ---- bounce rejection on A ----
    for (int i = 0; i < 20; i++) begin
      pin_a = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("bounce%0d rotAreg", i), ifw.rotAreg, 0);
      chk($sformatf("bounce%0d step", i), ifw.step, 0);
    end
    pin_a = 1'b1;
    run_win(8, sw, ss, ew, pr, rl);
    chk("bounce steps", sw, 0);

    // ---- table: detents, wrap/saturation, reversal, illegal ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive_ab(vecs[i].ab);
      run_win(8, sw, ss, ew, pr, rl);
      chk($sformatf("vec%0d steps_w", i), sw, vecs[i].steps);
      chk($sformatf("vec%0d steps_s", i), ss, vecs[i].steps);
      chk($sformatf("vec%0d errors", i), ew, vecs[i].errs);
      chk($sformatf("vec%0d dir_w", i), ifw.dir, vecs[i].dir);
      chk($sformatf("vec%0d dir_s", i), ifs.dir, vecs[i].dir);
      chk($sformatf("vec%0d pos_w", i), ifw.position, vecs[i].pos_w);
      chk($sformatf("vec%0d pos_s", i), ifs.position, vecs[i].pos_s);
    end

    // ---- clear on the step cycle (position 5 on the wrapping instance) ----
    drive_ab(S00); run_win(8, sw, ss, ew, pr, rl);
    drive_ab(S10); run_win(8, sw, ss, ew, pr, rl);
    drive_ab(S11); run_win(8, sw, ss, ew, pr, rl);
    chk("pre-clear steps", sw, 0);
    chk("pre-clear pos_w", ifw.position, 5);
    drive_ab(S01);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("step latency %0d", i), ifw.step, 0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear step_w", ifw.step, 1);
    chk("clear step_s", ifs.step, 1);
    chk("clear dir", ifw.dir, 1);
    chk("clear pos_w", ifw.position, 0);
    chk("clear pos_s", ifs.position, 0);
    tick();
    chk("step one cycle", ifw.step, 0);
    chk("post-clear pos_w", ifw.position, 0);

    // ---- button release, press, glitch ----
    pin_c = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("fall%0d rotCTRreg", i), ifw.rotCTRreg, (i < 4) ? 1 : 0);
      chk($sformatf("fall%0d release", i), ifw.release_o, (i == 5) ? 1 : 0);
      chk($sformatf("fall%0d press", i), ifw.press, 0);
    end
    pin_c = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("rise%0d rotCTRreg", i), ifw.rotCTRreg, (i >= 4) ? 1 : 0);
      chk($sformatf("rise%0d press", i), ifw.press, (i == 5) ? 1 : 0);
      chk($sformatf("rise%0d release", i), ifw.release_o, 0);
    end
    pin_c = 1'b0;
    run_win(3, sw, ss, ew, pr, rl);
    pin_c = 1'b1;
    begin
      int pr2, rl2;
      run_win(6, sw, ss, ew, pr2, rl2);
      chk("glitch press", pr + pr2, 0);
      chk("glitch release", rl + rl2, 0);
      chk("glitch rotCTRreg", ifw.rotCTRreg, 1);
    end

    // ---- reset mid-detent discards acc ----
    drive_ab(S00); run_win(8, sw, ss, ew, pr, rl);
    drive_ab(S10); run_win(8, sw, ss, ew, pr, rl);
    chk("pre-reset steps", sw, 0);
    reset = 1'b1;
    tick(); tick();
    chk("mid-reset position", ifw.position, 0);
    chk("mid-reset dir", ifw.dir, 0);
    chk("mid-reset rotAreg", ifw.rotAreg, 0);
    reset = 1'b0;
    run_win(10, sw, ss, ew, pr, rl);
    chk("rearm steps", sw, 0);
    chk("rearm press", pr, 0);
    chk("rearm error", ew, 0);
    drive_ab(S11); run_win(8, sw, ss, ew, pr, rl);
    drive_ab(S01); run_win(8, sw, ss, ew, pr, rl);
    chk("partial discarded steps", sw, 0);
    drive_ab(S00); run_win(8, sw, ss, ew, pr, rl);
    drive_ab(S10); run_win(8, sw, ss, ew, pr, rl);
    chk("post-reset step", sw, 1);
    chk("post-reset dir", ifw.dir, 1);
    chk("post-reset pos_w", ifw.position, 1);
    chk("post-reset pos_s", ifs.position, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
